// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcoded CPU control unit: control-word bit
// positions, ALU operation codes, instruction opcodes and FSM state codes.
package cpu_ctrl_pkg;

    // Control word widths
    localparam int LD_W = 9;
    localparam int TR_W = 6;

    // LoadSignal bit positions
    localparam int LD_R   = 0;
    localparam int LD_PC  = 1;
    localparam int LD_SP  = 2;
    localparam int LD_F   = 3;
    localparam int LD_T   = 4;
    localparam int LD_MAR = 5;
    localparam int LD_MDM = 6;
    localparam int LD_MDZ = 7;
    localparam int LD_IR  = 8;

    // TransferSignal bit positions (bus drivers, at most one active)
    localparam int TR_R   = 0;
    localparam int TR_PC  = 1;
    localparam int TR_SP  = 2;
    localparam int TR_MAR = 3;
    localparam int TR_MDR = 4;
    localparam int TR_L   = 5;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_PASSX = 3'b101;
    localparam logic [2:0] ALU_INCX  = 3'b110;
    localparam logic [2:0] ALU_DECX  = 3'b111;

    // Opcodes in IR[14:12] when IR[15] = 0
    localparam logic [2:0] OPC_PUSH = 3'b000;
    localparam logic [2:0] OPC_POP  = 3'b001;
    localparam logic [2:0] OPC_ALU  = 3'b010;
    localparam logic [2:0] OPC_CALL = 3'b011;
    localparam logic [2:0] OPC_RET  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b101;

    // FSM state encoding
    typedef logic [4:0] state_t;

    localparam state_t ST_F0   = 5'd0;   // fetch: PC -> MAR
    localparam state_t ST_F1   = 5'd1;   // fetch: read word, PC+1
    localparam state_t ST_DEC  = 5'd2;   // dispatch
    localparam state_t ST_P0   = 5'd3;   // PUSH: SP-1
    localparam state_t ST_P1   = 5'd4;   // PUSH: R -> MDR
    localparam state_t ST_P2   = 5'd5;   // PUSH: write
    localparam state_t ST_Q0   = 5'd6;   // POP: SP -> MAR
    localparam state_t ST_Q1   = 5'd7;   // POP: read
    localparam state_t ST_Q2   = 5'd8;   // POP: MDR -> R
    localparam state_t ST_Q3   = 5'd9;   // POP: SP+1
    localparam state_t ST_A0   = 5'd10;  // ALU: SP -> MAR
    localparam state_t ST_A1   = 5'd11;  // ALU: read first operand
    localparam state_t ST_A2   = 5'd12;  // ALU: MDR -> T
    localparam state_t ST_A3   = 5'd13;  // ALU: SP+1 -> SP, MAR
    localparam state_t ST_A4   = 5'd14;  // ALU: read second operand
    localparam state_t ST_A5   = 5'd15;  // ALU: compute, flags
    localparam state_t ST_A6   = 5'd16;  // ALU: write result
    localparam state_t ST_B0   = 5'd17;  // branch: PC -> T
    localparam state_t ST_B1   = 5'd18;  // branch: T + offset -> PC
    localparam state_t ST_C0   = 5'd19;  // CALL: SP-1
    localparam state_t ST_C1   = 5'd20;  // CALL: PC -> MDR
    localparam state_t ST_C2   = 5'd21;  // CALL: write return address
    localparam state_t ST_R0   = 5'd22;  // RET: SP -> MAR
    localparam state_t ST_R1   = 5'd23;  // RET: read return address
    localparam state_t ST_R2   = 5'd24;  // RET: MDR -> PC
    localparam state_t ST_R3   = 5'd25;  // RET: SP+1
    localparam state_t ST_HALT = 5'd26;  // stopped until reset

    // Decoded control word produced by the decoder each cycle
    typedef struct packed {
        logic [LD_W-1:0] load;
        logic [TR_W-1:0] xfer;
        logic [2:0]      alop;
        logic            mem_read;
        logic            mem_write;
        logic            halted;
    } ctrl_t;

    // ALU opcodes above XOR are undefined and execute as NOP
    function automatic logic alu_op_valid(input logic [2:0] op);
        return (op <= ALU_XOR);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decoder: registered state (plus IR op field and
// memory Ready) -> load/transfer/ALU/memory strobes.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] state,
    input  logic [2:0] alu_op,
    input  logic       ready,
    output ctrl_t      sig
);

    // Per-state control word; register loads in wait states only on Ready
    always_comb begin
        sig = '0;
        case (state)
            ST_F0: begin
                sig.xfer[TR_PC]  = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_MAR] = 1'b1;
            end
            ST_F1: begin
                sig.mem_read = 1'b1;
                if (ready) begin
                    sig.load[LD_IR] = 1'b1;
                    sig.xfer[TR_PC] = 1'b1;
                    sig.alop        = ALU_INCX;
                    sig.load[LD_PC] = 1'b1;
                end
            end
            ST_P0, ST_C0: begin
                sig.xfer[TR_SP]  = 1'b1;
                sig.alop         = ALU_DECX;
                sig.load[LD_SP]  = 1'b1;
                sig.load[LD_MAR] = 1'b1;
            end
            ST_P1: begin
                sig.xfer[TR_R]   = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_MDZ] = 1'b1;
            end
            ST_C1: begin
                sig.xfer[TR_PC]  = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_MDZ] = 1'b1;
            end
            ST_P2, ST_A6, ST_C2: begin
                sig.mem_write = 1'b1;
            end
            ST_Q0, ST_A0, ST_R0: begin
                sig.xfer[TR_SP]  = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_MAR] = 1'b1;
            end
            ST_Q1, ST_A1, ST_A4, ST_R1: begin
                sig.mem_read = 1'b1;
                if (ready) begin
                    sig.load[LD_MDM] = 1'b1;
                end
            end
            ST_Q2: begin
                sig.xfer[TR_MDR] = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_R]   = 1'b1;
            end
            ST_R2: begin
                sig.xfer[TR_MDR] = 1'b1;
                sig.alop         = ALU_PASSX;
                sig.load[LD_PC]  = 1'b1;
            end
            ST_Q3, ST_R3: begin
                sig.xfer[TR_SP] = 1'b1;
                sig.alop        = ALU_INCX;
                sig.load[LD_SP] = 1'b1;
            end
            ST_A2: begin
                sig.xfer[TR_MDR] = 1'b1;
                sig.load[LD_T]   = 1'b1;
            end
            ST_A3: begin
                sig.xfer[TR_SP]  = 1'b1;
                sig.alop         = ALU_INCX;
                sig.load[LD_SP]  = 1'b1;
                sig.load[LD_MAR] = 1'b1;
            end
            ST_A5: begin
                sig.xfer[TR_MDR] = 1'b1;
                sig.alop         = alu_op;
                sig.load[LD_MDZ] = 1'b1;
                sig.load[LD_F]   = 1'b1;
            end
            ST_B0: begin
                sig.xfer[TR_PC] = 1'b1;
                sig.load[LD_T]  = 1'b1;
            end
            ST_B1: begin
                sig.xfer[TR_L]  = 1'b1;
                sig.alop        = ALU_ADD;
                sig.load[LD_PC] = 1'b1;
            end
            ST_HALT: begin
                sig.halted = 1'b1;
            end
            default: begin
                // DEC and unused codes drive nothing
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// CPU control unit: state register with next-state sequencing, a separate
// combinational decoder for the control word, and reset gating of outputs.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     Instruction,
    input  logic            Status,
    input  logic            Ready,
    output logic [LD_W-1:0] LoadSignal,
    output logic [TR_W-1:0] TransferSignal,
    output logic [2:0]      ALOP,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Halted
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  dec_sig;

    // The branch offset field is consumed by the datapath, not here
    logic unused_ir_bits;
    assign unused_ir_bits = ^Instruction[11:3];

    // State register; reset forces fetch from any state, including waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_F0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing; wait states advance only on Ready
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_F0:   state_next = ST_F1;
            ST_F1:   if (Ready) state_next = ST_DEC;
            ST_DEC: begin
                if (Instruction[15]) begin
                    state_next = Status ? ST_B0 : ST_F0;
                end else begin
                    case (Instruction[14:12])
                        OPC_PUSH: state_next = ST_P0;
                        OPC_POP:  state_next = ST_Q0;
                        OPC_ALU:  state_next = alu_op_valid(Instruction[2:0]) ? ST_A0 : ST_F0;
                        OPC_CALL: state_next = ST_C0;
                        OPC_RET:  state_next = ST_R0;
                        OPC_HALT: state_next = ST_HALT;
                        default:  state_next = ST_F0;
                    endcase
                end
            end
            ST_P0:   state_next = ST_P1;
            ST_P1:   state_next = ST_P2;
            ST_P2:   if (Ready) state_next = ST_F0;
            ST_Q0:   state_next = ST_Q1;
            ST_Q1:   if (Ready) state_next = ST_Q2;
            ST_Q2:   state_next = ST_Q3;
            ST_Q3:   state_next = ST_F0;
            ST_A0:   state_next = ST_A1;
            ST_A1:   if (Ready) state_next = ST_A2;
            ST_A2:   state_next = ST_A3;
            ST_A3:   state_next = ST_A4;
            ST_A4:   if (Ready) state_next = ST_A5;
            ST_A5:   state_next = ST_A6;
            ST_A6:   if (Ready) state_next = ST_F0;
            ST_B0:   state_next = ST_B1;
            ST_B1:   state_next = ST_F0;
            ST_C0:   state_next = ST_C1;
            ST_C1:   state_next = ST_C2;
            ST_C2:   if (Ready) state_next = ST_B0;
            ST_R0:   state_next = ST_R1;
            ST_R1:   if (Ready) state_next = ST_R2;
            ST_R2:   state_next = ST_R3;
            ST_R3:   state_next = ST_F0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_F0;
        endcase
    end

    control_decode u_decode (
        .state  (state_reg),
        .alu_op (Instruction[2:0]),
        .ready  (Ready),
        .sig    (dec_sig)
    );

    // Outputs are forced low for as long as reset is held
    for (genvar gi = 0; gi < LD_W; gi++) begin : g_load
        assign LoadSignal[gi] = dec_sig.load[gi] & ~reset;
    end

    for (genvar gi = 0; gi < TR_W; gi++) begin : g_xfer
        assign TransferSignal[gi] = dec_sig.xfer[gi] & ~reset;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_alop
        assign ALOP[gi] = dec_sig.alop[gi] & ~reset;
    end

    assign MemRead  = dec_sig.mem_read  & ~reset;
    assign MemWrite = dec_sig.mem_write & ~reset;
    assign Halted   = dec_sig.halted    & ~reset;

endmodule
